w_pattern_tx: RTL and testbench
===============================

# w_pattern_tx

Serial stimulus transmitter for the `w`-input sequence-detector FSMs. It accepts a parallel pattern and a bit count, then shifts the pattern out one bit per clock on `w`, MSB first. Alongside `w` it produces `ExpZ`, a registered copy of the `z` that a Moore detector for "RUN consecutive equal bits" must show. A detector and a `w_pattern_tx` can be wired back-to-back on the same `Clock` and checked against each other on board or in simulation.

## Interface
Parameters:
- `WIDTH`, 16: pattern register width in bits.
- `LEN_W`, 5: width of `Length`. Must hold the value `WIDTH`.
- `RUN`, 4: run length that sets `ExpZ`.

Ports:
- `Clock`, in, 1: single clock. All state changes on the rising edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `Start`, in, 1: request a frame. Sampled on the rising edge.
- `Pattern`, in, `WIDTH`: bits to send. Captured when `Start` is accepted.
- `Length`, in, `LEN_W`: number of bits to send. Captured with `Pattern`.
- `w`, out, 1: serial data bit.
- `Valid`, out, 1: high while `w` carries a frame bit.
- `Busy`, out, 1: high from frame acceptance through the `Done` cycle.
- `Done`, out, 1: one-cycle pulse when a frame ends.
- `ExpZ`, out, 1: expected detector output, aligned with a Moore detector's `z`.

## Operation
- States:
  - IDLE: `Busy`=0.
  - SEND: `Valid`=1, `Busy`=1.
  - DONE: `Done`=1, `Busy`=1.
- State transitions:
  - IDLE -> SEND on `Start`=1 with `Length`!=0.
  - IDLE -> DONE on `Start`=1 with `Length`=0. No bits are sent.
  - SEND -> DONE after the last bit.
  - DONE -> IDLE unconditionally.
- Acceptance:
  - `Start` is honoured only in IDLE. In SEND and DONE it is ignored; it is not queued.
  - Later changes to `Pattern` or `Length` do not affect the frame in flight.
- Length clamp: a `Length` greater than `WIDTH` is clamped to `WIDTH`.
- Bit order: transmits `Pattern[WIDTH-1]` down to `Pattern[WIDTH-L]`, where L is the clamped length. The pattern is left-justified.
- Run counter:
  - Saturating counter, 0..`RUN`. Updated on each edge that consumes a bit.
  - Equal to the previous bit: increment. Different bit, or first bit of the frame: set to 1.
  - Cleared on entry to SEND and in IDLE. Runs never span frames.
- `ExpZ` is registered. On the edge consuming bit i, `ExpZ` <= (run count including bit i >= `RUN`). It is forced to 0 on the edge leaving DONE.
- Idle values: `w`=0, `Valid`=0, `ExpZ`=0 whenever not in SEND, except for the DONE-cycle `ExpZ` defined above.
- Reset (any time, including mid-frame):
  - Takes effect immediately: state=IDLE.
  - `w`, `Valid`, `Busy`, `Done`, `ExpZ` = 0. Shift register and run counter cleared.
  - The frame in flight is discarded, with no `Done` pulse.
  - The first `Start` is accepted on the first rising edge after `Reset` returns high.

## Timing
- Let edge k be the edge that accepts `Start`, and L the clamped length.
- Bit i (0..L-1) is driven on `w` with `Valid`=1 from edge k+i to edge k+i+1. Latency from `Start` to the first bit is 0 cycles after the accepting edge.
- `ExpZ` for bit i is valid from edge k+i+1 to edge k+i+2. This matches a Moore detector that samples `w` at edge k+i+1.
- End of frame:
  - `Valid` falls at edge k+L.
  - `Done`=1 from edge k+L to edge k+L+1.
  - `Busy` falls at edge k+L+1, which is also the earliest edge that can accept the next `Start`.
- Zero-length frame: `Done`=1 from edge k+1 to edge k+2, and `Busy` falls at edge k+2. (The IDLE -> DONE transition takes one cycle, so acceptance and `Done` are not in the same cycle.)
- Outputs are all registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle:
  - Stimulus: hold `Reset`=0, release, idle 5 cycles.
  - Required: all outputs 0 throughout.
- Basic frame:
  - Stimulus: `Pattern`=16'hF0F0, `Length`=8, `Start` accepted at edge k.
  - Required: `w`=1,1,1,1,0,0,0,0 from k; `ExpZ`=1 only in cycles k+4 and k+8; `Done` in cycle k+8; `Busy` falls at k+9.
- Long run and saturation:
  - Stimulus: `Pattern`=16'hFFC0, `Length`=10.
  - Required: ten 1s on `w`; `ExpZ`=1 in cycles k+4 through k+10; `ExpZ`=0 from k+11.
- Length edge cases:
  - Stimulus: `Length`=0.
  - Required: `Valid` never asserts; `Done` in cycle k+1; `Busy` falls at k+2.
  - Stimulus: `Length`=20.
  - Required: exactly 16 bits sent; `Done` in cycle k+16.
- Start while busy:
  - Stimulus: pulse `Start` with new data at k+3 of an 8-bit frame, and again during the DONE cycle.
  - Required: original frame unchanged; no second frame starts.
- Reset mid-frame:
  - Stimulus: drop `Reset` between edges k+2 and k+3 of an 8-bit frame.
  - Required: `w`, `Valid`, `Busy`, `ExpZ` go to 0 immediately; no `Done`; the next `Start` sends a full fresh frame with the run counter starting at 1.

Source files
------------

// File: rtl/w_pattern_tx.sv
// w_pattern_tx: serial stimulus source for w-input sequence detectors.
// Shifts a left-justified pattern out MSB first on w and produces ExpZ,
// the registered z a Moore "RUN consecutive equal bits" detector must show.
module w_pattern_tx #(
   parameter int WIDTH = 16,
   parameter int LEN_W = 5,
   parameter int RUN   = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Pattern,
   input  logic [LEN_W-1:0] Length,
   output logic             w,
   output logic             Valid,
   output logic             Busy,
   output logic             Done,
   output logic             ExpZ
);

   localparam int RUN_W = $clog2(RUN + 1);

   // EMPTY is the one-cycle gap between accepting a zero-length frame and its
   // Done pulse, so Done never coincides with the accepting edge.
   typedef enum logic [1:0] {IDLE, SEND, EMPTY, DONE} state_t;

   state_t             state;
   logic [WIDTH-1:0]   shreg;    // bits still to send after the one on w
   logic [LEN_W-1:0]   remain;   // bits left after the current one
   logic [RUN_W-1:0]   run;      // run length including the last consumed bit
   logic               prev;     // last consumed bit
   logic [LEN_W-1:0]   len_c;
   logic [RUN_W-1:0]   run_nxt;

   // Clamp oversize lengths to the pattern width.
   always_comb begin
      len_c = Length;
      if (Length > LEN_W'(WIDTH)) len_c = LEN_W'(WIDTH);
   end

   // Run count after consuming the bit now on w (run==0 marks the first bit).
   always_comb begin
      run_nxt = RUN_W'(1);
      if (run != '0 && w == prev) begin
         if (run == RUN_W'(RUN)) run_nxt = run;
         else                    run_nxt = run + RUN_W'(1);
      end
   end

   // Frame FSM with all outputs registered.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= IDLE;
         shreg  <= '0;
         remain <= '0;
         run    <= '0;
         prev   <= 1'b0;
         w      <= 1'b0;
         Valid  <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
         ExpZ   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               run   <= '0;
               w     <= 1'b0;
               Valid <= 1'b0;
               Done  <= 1'b0;
               ExpZ  <= 1'b0;
               if (Start) begin
                  Busy <= 1'b1;
                  if (len_c == '0) begin
                     state <= EMPTY;
                  end else begin
                     state  <= SEND;
                     w      <= Pattern[WIDTH-1];
                     Valid  <= 1'b1;
                     shreg  <= {Pattern[WIDTH-2:0], 1'b0};
                     remain <= len_c - LEN_W'(1);
                  end
               end
            end
            SEND: begin
               // This edge consumes the bit on w.
               run  <= run_nxt;
               prev <= w;
               ExpZ <= (run_nxt >= RUN_W'(RUN));
               if (remain == '0) begin
                  state <= DONE;
                  w     <= 1'b0;
                  Valid <= 1'b0;
                  Done  <= 1'b1;
               end else begin
                  w      <= shreg[WIDTH-1];
                  shreg  <= {shreg[WIDTH-2:0], 1'b0};
                  remain <= remain - LEN_W'(1);
               end
            end
            EMPTY: begin
               state <= DONE;
               Done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               Done  <= 1'b0;
               Busy  <= 1'b0;
               ExpZ  <= 1'b0;
               run   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_w_pattern_tx.sv
// Scoreboard bench for w_pattern_tx: stimulus pushes one expected output
// record per cycle; the monitor pops and compares on every falling edge.
module tb_w_pattern_tx;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [15:0] Pattern;
   logic [4:0]  Length;
   logic        w, Valid, Busy, Done, ExpZ;

   typedef struct {
      logic [4:0] v;   // {w, Valid, Busy, Done, ExpZ}
      string      tag;
   } rec_t;

   rec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   w_pattern_tx #(.WIDTH(16), .LEN_W(5), .RUN(4)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Pattern(Pattern),
      .Length(Length), .w(w), .Valid(Valid), .Busy(Busy), .Done(Done),
      .ExpZ(ExpZ)
   );

   always #5 Clock = ~Clock;

   // Monitor: compare DUT outputs with the next expected record.
   always @(negedge Clock) begin
      if (sb.size() > 0) begin
         rec_t r;
         r = sb.pop_front();
         checks++;
         if ({w, Valid, Busy, Done, ExpZ} !== r.v) begin
            errors++;
            $display("FAIL %s got {w,V,B,D,Z}=%b want %b", r.tag,
                     {w, Valid, Busy, Done, ExpZ}, r.v);
         end
      end
   end

   task automatic push(input logic [4:0] v, input string tag);
      rec_t r;
      r.v = v;
      r.tag = tag;
      sb.push_back(r);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge Clock);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
         sb.delete();
      end
   endtask

   // Issue one frame; expz bit c is ExpZ in cycle c after the accepting edge.
   // ncyc truncates the frame records (for reset aborts); nidle trails idle.
   task automatic send(input string name, input logic [15:0] pat,
                       input logic [4:0] len, input int lc,
                       input logic [31:0] expz, input int ncyc,
                       input int nidle);
      wait_empty();
      @(posedge Clock); #1;
      Start = 1'b1; Pattern = pat; Length = len;
      push(5'b0, {name, " pre"});
      if (lc == 0) begin
         push(5'b00100, {name, " c0"});
         push(5'b00110, {name, " c1"});
      end else begin
         for (int c = 0; c <= lc; c++) begin
            if (c < ncyc) begin
               if (c < lc) push({pat[15-c], 3'b110, expz[c]}, $sformatf("%s c%0d", name, c));
               else        push({4'b0011, expz[c]}, $sformatf("%s c%0d", name, c));
            end
         end
      end
      for (int i = 0; i < nidle; i++) push(5'b0, $sformatf("%s idle%0d", name, i));
      @(posedge Clock); #1;
      Start = 1'b0;
      Pattern = 16'($urandom);
      Length = 5'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b1; Start = 1'b0; Pattern = '0; Length = '0;
      #2 Reset = 1'b0;
      for (int i = 0; i < 3; i++) push(5'b0, $sformatf("rst%0d", i));
      repeat (3) @(negedge Clock);
      #1 Reset = 1'b1;
      for (int i = 0; i < 5; i++) push(5'b0, $sformatf("idle%0d", i));

      send("basic", 16'hF0F0, 5'd8, 8, 32'h110, 99, 2);
      send("sat", 16'hFFC0, 5'd10, 10, 32'h7F0, 99, 2);
      send("len0", 16'hFFFF, 5'd0, 0, 32'h0, 99, 2);
      send("len20", 16'h0FFF, 5'd20, 16, 32'h1FF10, 99, 2);

      // Start pulses during SEND (edge k+3) and during DONE (edge k+9).
      send("busy", 16'h3C00, 5'd8, 8, 32'h40, 99, 3);
      repeat (2) @(posedge Clock); #1;
      Start = 1'b1; Pattern = 16'hFFFF; Length = 5'd4;
      @(posedge Clock); #1 Start = 1'b0;
      repeat (5) @(posedge Clock); #1;
      Start = 1'b1; Pattern = 16'hFFFF; Length = 5'd4;
      @(posedge Clock); #1 Start = 1'b0;

      // Reset dropped between edges k+2 and k+3.
      send("abort", 16'hFFFF, 5'd8, 8, 32'h0, 3, 3);
      @(posedge Clock);
      @(posedge Clock);
      #6 Reset = 1'b0;
      #1;
      checks++;
      if ({w, Valid, Busy, Done, ExpZ} !== 5'b0) begin
         errors++;
         $display("FAIL async_reset got %b want 00000", {w, Valid, Busy, Done, ExpZ});
      end
      @(posedge Clock);
      @(posedge Clock); #1 Reset = 1'b1;
      send("fresh", 16'hFFFF, 5'd8, 8, 32'h1F0, 99, 2);

      wait_empty();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
